// File: rtl/alu_cmd_sequencer.sv
// Valid/ready command front-end for an external combinational ALU: registers the ALU inputs for one
// EXEC cycle, captures the result with flags, and keeps a chaining accumulator and an op counter.
module alu_cmd_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_sel,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_acc,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_neg,
    output logic             rsp_err,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t             state_q, state_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic [WIDTH-1:0]   alu_a_q, alu_a_d;
    logic [WIDTH-1:0]   alu_b_q, alu_b_d;
    logic [2:0]         alu_sel_q, alu_sel_d;
    logic               ill_q, ill_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]   rsp_result_q, rsp_result_d;
    logic               rsp_zero_q, rsp_zero_d;
    logic               rsp_neg_q, rsp_neg_d;
    logic               rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]   op_count_q, op_count_d;

    logic [WIDTH-1:0]   a_eff;
    logic               legal;

    always_comb begin
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_sel_d    = alu_sel_q;
        ill_d        = ill_q;
        acc_d        = acc_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_neg_d    = rsp_neg_q;
        rsp_err_d    = rsp_err_q;
        op_count_d   = op_count_q;
        a_eff        = cmd_acc ? acc_q : cmd_a;
        legal        = (cmd_sel <= 3'd4);

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    // Illegal op codes never reach the ALU: its inputs stay at zero.
                    state_d   = EXEC;
                    ill_d     = !legal;
                    alu_a_d   = legal ? a_eff   : '0;
                    alu_b_d   = legal ? cmd_b   : '0;
                    alu_sel_d = legal ? cmd_sel : 3'd0;
                end
            end
            EXEC: begin
                state_d      = RESP;
                alu_a_d      = '0;
                alu_b_d      = '0;
                alu_sel_d    = 3'd0;
                rsp_valid_d  = 1'b1;
                rsp_result_d = ill_q ? '0 : alu_result;
                rsp_zero_d   = ill_q || (alu_result == '0);
                rsp_neg_d    = !ill_q && alu_result[WIDTH-1];
                rsp_err_d    = ill_q;
                if (!ill_q) begin
                    acc_d = alu_result;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: state_d = IDLE;
        endcase

        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cmd_ready_q  <= 1'b1;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= 3'd0;
            ill_q        <= 1'b0;
            acc_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_neg_q    <= 1'b0;
            rsp_err_q    <= 1'b0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            cmd_ready_q  <= cmd_ready_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_sel_q    <= alu_sel_d;
            ill_q        <= ill_d;
            acc_q        <= acc_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_neg_q    <= rsp_neg_d;
            rsp_err_q    <= rsp_err_d;
            op_count_q   <= op_count_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_neg    = rsp_neg_q;
    assign rsp_err    = rsp_err_q;
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a behavioural ALU on the alu_* ports.
module tb_alu_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_sel = 3'd0;
    logic [7:0]  cmd_a = 8'd0;
    logic [7:0]  cmd_b = 8'd0;
    logic        cmd_acc = 1'b0;
    logic [7:0]  alu_a, alu_b, alu_result;
    logic [2:0]  alu_sel;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [7:0]  rsp_result;
    logic        rsp_zero, rsp_neg, rsp_err;
    logic [15:0] op_count;

    alu_cmd_sequencer #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_acc(cmd_acc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_neg(rsp_neg), .rsp_err(rsp_err), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // The combinational ALU the sequencer fronts.
    always_comb begin
        case (alu_sel)
            3'd0:    alu_result = alu_a + alu_b;
            3'd1:    alu_result = alu_a - alu_b;
            3'd2:    alu_result = alu_a & alu_b;
            3'd3:    alu_result = alu_a | alu_b;
            3'd4:    alu_result = ~alu_a;
            default: alu_result = 8'd0;
        endcase
    end

    typedef struct {
        int res;
        bit z, n, e;
        int acc_cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   model_acc = 0;
    int   model_cnt = 0;
    int   exec_cyc = -1;
    int   exp_alu_a = 0, exp_alu_b = 0, exp_alu_sel = 0;
    bit   front_seen = 0;
    bit   started = 0;
    int   ready_mode = 0;   // 0: always ready, 1: random, 2: held low

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       rsp_ready = 1'b1;
                2:       rsp_ready = 1'b0;
                default: rsp_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    // Monitor: samples at the falling edge, compares against the scoreboard front.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            model_cnt  = 0;
            exec_cyc   = -1;
            front_seen = 0;
        end else if (started) begin
            chk("cmd_ready", int'(cmd_ready), int'(q.size() == 0));
            chk("op_count", int'(op_count), model_cnt);
            if (cyc == exec_cyc) begin
                chk("alu_a_exec", int'(alu_a), exp_alu_a);
                chk("alu_b_exec", int'(alu_b), exp_alu_b);
                chk("alu_sel_exec", int'(alu_sel), exp_alu_sel);
            end else begin
                chk("alu_idle", int'({alu_a, alu_b, 5'd0, alu_sel}), 0);
            end
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_rsp_valid", 1, 0);
                end else begin
                    if (!front_seen) begin
                        // visible one cycle after EXEC: sampled by the second edge after accept
                        chk("rsp_latency", cyc - q[0].acc_cyc, 1);
                        front_seen = 1;
                    end
                    chk("rsp_result", int'(rsp_result), q[0].res);
                    chk("rsp_zero", int'(rsp_zero), int'(q[0].z));
                    chk("rsp_neg", int'(rsp_neg), int'(q[0].n));
                    chk("rsp_err", int'(rsp_err), int'(q[0].e));
                    if (rsp_ready) begin
                        void'(q.pop_front());
                        front_seen = 0;
                        model_cnt  = (model_cnt + 1) % 65536;
                    end
                end
            end
        end
    end

    task automatic send(input int sel, input int a, input int b, input bit use_acc);
        int   n;
        bit   rdy;
        int   ae, r;
        bit   legal;
        exp_t e;
        cmd_valid = 1'b1;
        cmd_sel   = sel[2:0];
        cmd_a     = a[7:0];
        cmd_b     = b[7:0];
        cmd_acc   = use_acc;
        n   = 0;
        rdy = 0;
        while (!rdy && n < 50) begin
            @(negedge clk);
            rdy = cmd_ready;
            @(posedge clk);
            n++;
        end
        #1;
        cmd_valid = 1'b0;
        cmd_sel   = 3'($urandom);
        cmd_a     = 8'($urandom);
        cmd_b     = 8'($urandom);
        cmd_acc   = 1'($urandom);
        if (!rdy) begin
            chk("accept_timeout", 0, 1);
            return;
        end
        ae    = use_acc ? model_acc : (a % 256);
        legal = (sel <= 4);
        case (sel)
            0:       r = (ae + b) % 256;
            1:       r = (ae - b + 256) % 256;
            2:       r = ae & b;
            3:       r = ae | b;
            4:       r = 255 - ae;
            default: r = 0;
        endcase
        if (legal) model_acc = r;
        exp_alu_a   = legal ? ae : 0;
        exp_alu_b   = legal ? b : 0;
        exp_alu_sel = legal ? sel : 0;
        exec_cyc    = cyc;
        e.res = r;
        e.z = (r == 0);
        e.n = (r >= 128);
        e.e = !legal;
        e.acc_cyc = cyc;
        q.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_rsp_valid", int'(rsp_valid), 0);
        chk("reset_rsp_flags", int'({rsp_result, rsp_zero, rsp_neg, rsp_err}), 0);
        chk("reset_cmd_ready", int'(cmd_ready), 1);
        started = 1;
        @(posedge clk);
        #1;

        send(0, 10, 5, 0);
        send(1, 20, 7, 0);
        send(2, 8'hCC, 8'hAA, 0);
        send(3, 8'hCC, 8'hAA, 0);
        send(4, 8'hF0, 0, 0);
        send(5, 9, 9, 0);
        send(0, 0, 1, 1);
        send(0, 200, 100, 0);
        send(0, 0, 10, 1);
        send(1, 0, 54, 1);
        send(1, 5, 7, 0);
        drain();

        ready_mode = 2;
        send(0, 1, 2, 0);
        repeat (5) @(posedge clk);
        #1;
        ready_mode = 0;
        drain();

        send(0, 10, 5, 0);
        rst = 1'b1;
        model_acc = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(0, 0, 7, 1);
        drain();

        ready_mode = 1;
        for (int i = 0; i < 60; i++) begin
            send($urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255),
                 1'($urandom));
        end
        ready_mode = 0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
